// File: rtl/sort_ctrl_if.sv
// Valid/ready packet stream carrying one word per beat with start/end-of-packet markers.
interface sort_ctrl_if #(
   parameter int DWIDTH = 10
);
   logic [DWIDTH-1:0] data;
   logic              startofpacket;
   logic              endofpacket;
   logic              valid;
   logic              ready;

   modport master (output data, startofpacket, endofpacket, valid, input ready);
   modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sort_ctrl.sv
// Sequencer for the in-RAM bubble sorter: loads a packet into RAM, lets the sorter
// own the RAM until done, then streams the sorted words out through a skid buffer.
//
// state  | meaning
// IDLE   | waiting for an sop beat; non-sop beats are dropped
// LOAD   | writing packet words to RAM via port A
// SORT   | sorter owns both RAM ports; sort_start held high
// UNLOAD | reading words 0..len-1 via port A and streaming them out
module sort_ctrl #(
   parameter int DWIDTH  = 10,
   parameter int ADDR_SZ = 10
) (
   input  logic               clk,
   input  logic               srst,
   sort_ctrl_if.slave         snk,
   sort_ctrl_if.master        src,
   output logic               sort_start,
   output logic [ADDR_SZ-1:0] sort_len,
   input  logic               sort_done,
   input  logic [ADDR_SZ-1:0] sort_address_a,
   input  logic [ADDR_SZ-1:0] sort_address_b,
   input  logic [DWIDTH-1:0]  sort_data_a,
   input  logic [DWIDTH-1:0]  sort_data_b,
   input  logic               sort_wren_a,
   input  logic               sort_wren_b,
   output logic [ADDR_SZ-1:0] ram_address_a,
   output logic [ADDR_SZ-1:0] ram_address_b,
   output logic [DWIDTH-1:0]  ram_data_a,
   output logic [DWIDTH-1:0]  ram_data_b,
   output logic               ram_wren_a,
   output logic               ram_wren_b,
   input  logic [DWIDTH-1:0]  ram_q_a,
   input  logic [DWIDTH-1:0]  ram_q_b
);

   typedef enum logic [1:0] {IDLE, LOAD, SORT, UNLOAD} state_t;

   state_t             state, state_nxt;
   logic [ADDR_SZ-1:0] wr_cnt, len, rd_addr;
   logic [ADDR_SZ-1:0] wr_addr, wr_nxt, last_addr;
   logic               wr_en, load_end, rd_done, issue, pop;
   logic               pend, pend_sop, pend_eop;
   logic               out_valid, out_sop, out_eop;
   logic               skid_valid, skid_sop, skid_eop;
   logic [DWIDTH-1:0]  out_data, skid_data;
   logic [1:0]         occ;

   always_comb begin
      wr_addr   = (state == IDLE || snk.startofpacket) ? '0 : wr_cnt;
      wr_en     = snk.valid && snk.ready && (state == LOAD || snk.startofpacket);
      wr_nxt    = wr_addr + ADDR_SZ'(1);
      load_end  = wr_en && (snk.endofpacket || (&wr_addr));
      last_addr = len - ADDR_SZ'(1);
      pop       = out_valid && src.ready;
      // Only fetch when the word will have a slot to land in next cycle.
      occ       = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(pop);
      issue     = (state == UNLOAD) && !rd_done && (occ <= 2'd1);

      state_nxt = state;
      case (state)
         IDLE, LOAD: begin
            if (load_end)
               state_nxt = (wr_nxt == ADDR_SZ'(1)) ? UNLOAD : SORT;
            else if (wr_en)
               state_nxt = LOAD;
         end
         SORT:    if (sort_done) state_nxt = UNLOAD;
         UNLOAD:  if (pop && out_eop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      snk.ready     = (state == IDLE) || (state == LOAD);
      sort_start    = (state == SORT) && !srst;
      sort_len      = len;
      ram_address_a = '0;
      ram_address_b = '0;
      ram_data_a    = '0;
      ram_data_b    = '0;
      ram_wren_a    = 1'b0;
      ram_wren_b    = 1'b0;
      case (state)
         IDLE, LOAD: begin
            ram_address_a = wr_addr;
            ram_data_a    = snk.data;
            ram_wren_a    = wr_en;
         end
         SORT: begin
            ram_address_a = sort_address_a;
            ram_address_b = sort_address_b;
            ram_data_a    = sort_data_a;
            ram_data_b    = sort_data_b;
            ram_wren_a    = sort_wren_a;
            ram_wren_b    = sort_wren_b;
         end
         UNLOAD:  ram_address_a = rd_addr;
         default: ;
      endcase

      src.data          = out_data;
      src.startofpacket = out_sop;
      src.endofpacket   = out_eop;
      src.valid         = out_valid;
   end

   always_ff @(posedge clk) begin
      if (srst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_cnt     <= '0;
         len        <= '0;
         rd_addr    <= '0;
         rd_done    <= 1'b0;
         pend       <= 1'b0;
         pend_sop   <= 1'b0;
         pend_eop   <= 1'b0;
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_sop   <= 1'b0;
         skid_eop   <= 1'b0;
         skid_data  <= '0;
      end else begin
         if (wr_en) begin
            wr_cnt <= wr_nxt;
            if (load_end) len <= wr_nxt;
         end
         if (state != UNLOAD) begin
            rd_addr    <= '0;
            rd_done    <= 1'b0;
            pend       <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            skid_valid <= 1'b0;
         end else begin
            pend     <= issue;
            pend_sop <= (rd_addr == '0);
            pend_eop <= (rd_addr == last_addr);
            if (issue) begin
               rd_addr <= rd_addr + ADDR_SZ'(1);
               if (rd_addr == last_addr) rd_done <= 1'b1;
            end
            if (pop || !out_valid) begin
               if (skid_valid) begin
                  out_valid  <= 1'b1;
                  out_data   <= skid_data;
                  out_sop    <= skid_sop;
                  out_eop    <= skid_eop;
                  skid_valid <= pend;
                  skid_data  <= ram_q_a;
                  skid_sop   <= pend_sop;
                  skid_eop   <= pend_eop;
               end else begin
                  out_valid <= pend;
                  out_data  <= ram_q_a;
                  out_sop   <= pend_sop;
                  out_eop   <= pend_eop;
               end
            end else if (pend) begin
               skid_valid <= 1'b1;
               skid_data  <= ram_q_a;
               skid_sop   <= pend_sop;
               skid_eop   <= pend_eop;
            end
         end
      end
   end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
Top-level sequencer for the in-RAM bubble sorter. It loads one packet from a valid/ready sink stream into the dual-port RAM and hands RAM ownership to the sorter. It waits for the sorter to finish, then streams the sorted words out on a valid/ready source stream. It owns the RAM port mux between itself and the sorter.

Parameters:
DWIDTH, 10, data word width.
ADDR_SZ, 10, RAM address width; DEPTH = 2**ADDR_SZ words.

Ports:
clk_i  in  1  clock.
srst_i  in  1  synchronous reset, active-high.
snk_data_i  in  DWIDTH  input word.
snk_startofpacket_i  in  1  first word of packet.
snk_endofpacket_i  in  1  last word of packet.
snk_valid_i  in  1  input beat valid.
snk_ready_o  out  1  input beat accepted when valid&&ready.
src_data_o  out  DWIDTH  sorted output word.
src_startofpacket_o  out  1  first output word.
src_endofpacket_o  out  1  last output word.
src_valid_o  out  1  output beat valid.
src_ready_i  in  1  downstream ready.
sort_start_o  out  1  to sorter sorting_i.
sort_len_o  out  ADDR_SZ  to sorter max_counter_i; word count, 0 means DEPTH.
sort_done_i  in  1  from sorter done_o.
sort_address_a_i, sort_address_b_i  in  ADDR_SZ  sorter RAM addresses.
sort_data_a_i, sort_data_b_i  in  DWIDTH  sorter write data.
sort_wren_a_i, sort_wren_b_i  in  1  sorter write enables.
ram_address_a_o, ram_address_b_o  out  ADDR_SZ  RAM addresses.
ram_data_a_o, ram_data_b_o  out  DWIDTH  RAM write data.
ram_wren_a_o, ram_wren_b_o  out  1  RAM write enables.
ram_q_a_i, ram_q_b_i  in  DWIDTH  RAM read data; registered, 1-cycle read latency; also fed to the sorter q_a/q_b directly.

Behaviour:
- Reset: state IDLE. snk_ready_o=1. All other outputs 0: src_valid/sop/eop, sort_start_o, sort_len_o, ram_wren_*, ram addresses.
- Reset mid-operation aborts immediately. sort_start_o drops in the same cycle. The partial packet is discarded and RAM contents are don't-care.
- States: IDLE, LOAD, SORT, UNLOAD.
- IDLE: snk_ready_o=1. Beats without sop are accepted and dropped. A beat with sop is written to address 0 via port A and wr_cnt becomes 1.
  - If that beat also has eop, go to UNLOAD with len=1 (sort skipped).
  - Otherwise go to LOAD.
- LOAD: snk_ready_o=1. Each accepted beat is written to address wr_cnt via port A and wr_cnt increments.
  - An sop beat restarts the packet: written to address 0, wr_cnt=1.
  - An eop beat, or the beat written to DEPTH-1 (truncation), ends the load. len = wr_cnt+1 mod DEPTH.
  - len==1 goes to UNLOAD; otherwise go to SORT.
  - Post-truncation beats have no sop and are dropped in later IDLE.
- SORT: snk_ready_o=0. sort_len_o=len, held stable. sort_start_o=1 from the first SORT cycle.
  - RAM ports mirror the sort_* inputs combinationally; the controller drives no RAM write.
  - When sort_done_i is sampled 1, deassert sort_start_o next cycle and go to UNLOAD.
- UNLOAD: snk_ready_o=0. Reads addresses 0..len-1 via port A (len 0 = DEPTH); port A wren=0.
  - First src_valid_o at most 2 cycles after entering UNLOAD.
  - One beat per cycle while src_ready_i=1.
  - Under backpressure, src_data/sop/eop/valid hold stable; no word is lost or duplicated (skid/prefetch register handles the read latency).
  - sop on beat 0, eop on beat len-1; both on the same beat for len=1.
  - eop accepted: next cycle is IDLE with snk_ready_o=1.
- Outside SORT, port B is idle: address 0, wren 0.
- Counters are ADDR_SZ wide and wrap mod DEPTH. Full-depth packets encode len=0 consistently on sort_len_o and in unload.
- snk_valid_i while snk_ready_o=0 is ignored; no beat is consumed.

Test Plan:
- Packet 5,3,9,1 (DWIDTH 10), src_ready_i=1: sort_len_o=4 during SORT. Output 1,3,5,9 with sop on 1 and eop on 9. Then IDLE, snk_ready_o=1.
- Single-word packet 7 (sop+eop): sort_start_o never asserts. Output 7 with sop=eop=1.
- ADDR_SZ=3, 10-beat packet: first 8 words sorted and output, sort_len_o=0, eop on 8th output. Trailing 2 input beats dropped; next sop packet sorts correctly.
- Random 16-word packet, src_ready_i toggling pseudo-randomly: 16 ascending beats, each value emitted once. Data/sop/eop stable whenever valid&&!ready.
- sop arriving at beat 3 of a LOAD: packet restarts. Only words from the new sop onward are sorted and output.
- srst_i pulsed during SORT: next cycle sort_start_o=0 and state IDLE. A following 4-word packet is output sorted correctly.
